// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter one byte at a time, with a cooldown
// cycle after each o_Tx_Done so no launch lands in the transmitter's cleanup.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset_n,
    input  logic                  i_Wr_En,
    input  logic [7:0]            i_Wr_Data,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    output logic                  o_Tx_DV,
    output logic [7:0]            o_Tx_Byte,
    input  logic                  i_Tx_Active,
    input  logic                  i_Tx_Done,
    output logic                  o_Busy
);

    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(2 ** DEPTH_LOG2);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        COOL      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [2**DEPTH_LOG2];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       txByte_q, txByte_d;
    logic             full_q, empty_q, overflow_q, txDv_q;
    logic             push, pop;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
    always_comb begin
        push     = i_Wr_En && (count_q != DEPTH_CNT);
        pop      = (state_q == IDLE) && (count_q != '0) && !i_Tx_Active;
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        txByte_d = txByte_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d  = rdPtr_q + PTR_W'(1);
            txByte_d = mem_q[rdPtr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (pop) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (i_Tx_Done) state_d = COOL;
            COOL:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q    <= IDLE;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            txByte_q   <= 8'h00;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            txDv_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            txByte_q   <= txByte_d;
            full_q     <= (count_d == DEPTH_CNT);
            empty_q    <= (count_d == '0);
            overflow_q <= i_Wr_En && (count_q == DEPTH_CNT);
            txDv_q     <= pop;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wrPtr_q] <= i_Wr_Data;
        end
    end

    assign o_Full     = full_q;
    assign o_Empty    = empty_q;
    assign o_Count    = count_q;
    assign o_Overflow = overflow_q;
    assign o_Tx_DV    = txDv_q;
    assign o_Tx_Byte  = txByte_q;
    assign o_Busy     = (state_q != IDLE);

endmodule
